// File: rtl/sound_scheduler.sv
// Sound request scheduler for the game_sounds player: queues one pending bit per
// sound type, grants in fixed priority, strobes the player and times its playback.
module sound_scheduler #(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int GUARD_CYCLES  = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sound_en,
    input  logic       req_start,
    input  logic       req_drop,
    input  logic       req_error,
    input  logic       req_victory,
    output logic       sound_start,
    output logic [1:0] sound_type,
    output logic       busy,
    output logic       coalesced
);

    localparam int D_LONG  = CLK_FREQ / 10;
    localparam int D_SHORT = CLK_FREQ / 25;

    // Player busy time per melody, plus its start synchroniser and an idle guard.
    localparam int WAIT_START   = 4  * (D_LONG  + 1) + 3 + GUARD_CYCLES;
    localparam int WAIT_DROP    = 2  * (D_SHORT + 1) + 3 + GUARD_CYCLES;
    localparam int WAIT_ERROR   = 2  * (D_LONG  + 1) + 3 + GUARD_CYCLES;
    localparam int WAIT_VICTORY = 13 * (D_LONG  + 1) + 3 + GUARD_CYCLES;
    localparam int WAIT_W       = $clog2(WAIT_VICTORY) + 1;

    localparam logic [1:0] TYPE_START   = 2'b00;
    localparam logic [1:0] TYPE_DROP    = 2'b01;
    localparam logic [1:0] TYPE_ERROR   = 2'b10;
    localparam logic [1:0] TYPE_VICTORY = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        PLAY
    } state_t;

    state_t            state, state_next;
    logic [3:0]        pending, pending_next;
    logic [3:0]        req_vec;
    logic [3:0]        merged;
    logic [3:0]        grant_mask;
    logic              grant;
    logic [1:0]        grant_type;
    logic [1:0]        strobe_cnt, strobe_cnt_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next, wait_load;
    logic              sound_start_next;
    logic [1:0]        sound_type_next;
    logic              busy_next;
    logic              coalesced_next;

    // Pending bit index equals the sound_type code.
    always_comb begin
        req_vec = {req_victory, req_error, req_drop, req_start};
    end

    always_comb begin
        grant_type = TYPE_DROP;
        if (pending[3]) begin
            grant_type = TYPE_VICTORY;
        end else if (pending[2]) begin
            grant_type = TYPE_ERROR;
        end else if (pending[0]) begin
            grant_type = TYPE_START;
        end
        grant      = (state == IDLE) && sound_en && (pending != 4'b0000);
        grant_mask = grant ? (4'b0001 << grant_type) : 4'b0000;
    end

    always_comb begin
        wait_load = WAIT_W'(WAIT_DROP - 1);
        case (sound_type)
            TYPE_START:   wait_load = WAIT_W'(WAIT_START - 1);
            TYPE_DROP:    wait_load = WAIT_W'(WAIT_DROP - 1);
            TYPE_ERROR:   wait_load = WAIT_W'(WAIT_ERROR - 1);
            TYPE_VICTORY: wait_load = WAIT_W'(WAIT_VICTORY - 1);
            default:      wait_load = WAIT_W'(WAIT_DROP - 1);
        endcase
    end

    // A request hitting an already-set bit (including the one being granted) merges.
    always_comb begin
        merged         = req_vec & pending;
        pending_next   = 4'b0000;
        coalesced_next = 1'b0;
        if (sound_en) begin
            pending_next   = (pending | req_vec) & ~grant_mask;
            coalesced_next = |merged;
        end
    end

    always_comb begin
        state_next       = state;
        sound_start_next = sound_start;
        sound_type_next  = sound_type;
        busy_next        = busy;
        strobe_cnt_next  = strobe_cnt;
        wait_cnt_next    = wait_cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    sound_type_next  = grant_type;
                    sound_start_next = 1'b0;
                    busy_next        = 1'b1;
                    strobe_cnt_next  = 2'(STROBE_CYCLES - 1);
                    state_next       = STROBE;
                end
            end
            STROBE: begin
                if (strobe_cnt == 2'd0) begin
                    sound_start_next = 1'b1;
                    wait_cnt_next    = wait_load;
                    state_next       = PLAY;
                end else begin
                    strobe_cnt_next = strobe_cnt - 2'd1;
                end
            end
            PLAY: begin
                // The player cannot be aborted, so muting does not shorten this.
                if (wait_cnt == '0) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt - WAIT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= 4'b0000;
            strobe_cnt  <= 2'd0;
            wait_cnt    <= '0;
            sound_start <= 1'b1;
            sound_type  <= TYPE_START;
            busy        <= 1'b0;
            coalesced   <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            strobe_cnt  <= strobe_cnt_next;
            wait_cnt    <= wait_cnt_next;
            sound_start <= sound_start_next;
            sound_type  <= sound_type_next;
            busy        <= busy_next;
            coalesced   <= coalesced_next;
        end
    end

endmodule

// File: tb/tb_sound_scheduler.sv
// Self-checking bench for sound_scheduler: scenario tasks plus randomized traffic,
// compared cycle by cycle against a timeline model of grants and busy windows.
module tb_sound_scheduler;

    localparam int CLK_FREQ      = 1000;
    localparam int GUARD_CYCLES  = 16;
    localparam int STROBE_CYCLES = 2;

    logic       clk;
    logic       rst_n;
    logic       sound_en;
    logic       req_start;
    logic       req_drop;
    logic       req_error;
    logic       req_victory;
    logic       sound_start;
    logic [1:0] sound_type;
    logic       busy;
    logic       coalesced;

    int tests_run    = 0;
    int tests_failed = 0;

    sound_scheduler #(
        .CLK_FREQ     (CLK_FREQ),
        .GUARD_CYCLES (GUARD_CYCLES),
        .STROBE_CYCLES(STROBE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sound_en   (sound_en),
        .req_start  (req_start),
        .req_drop   (req_drop),
        .req_error  (req_error),
        .req_victory(req_victory),
        .sound_start(sound_start),
        .sound_type (sound_type),
        .busy       (busy),
        .coalesced  (coalesced)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending set, cycles of busy left, cycles since the grant edge.
    logic [3:0] m_pend    = 4'b0000;
    int         m_left    = 0;
    int         m_elapsed = 0;
    logic [1:0] m_type    = 2'b00;
    logic       m_coal    = 1'b0;

    function automatic int melody_wait(input logic [1:0] t);
        int d_long;
        int d_short;
        d_long  = CLK_FREQ / 10;
        d_short = CLK_FREQ / 25;
        case (t)
            2'd0:    return 4  * (d_long  + 1) + 3 + GUARD_CYCLES;
            2'd1:    return 2  * (d_short + 1) + 3 + GUARD_CYCLES;
            2'd2:    return 2  * (d_long  + 1) + 3 + GUARD_CYCLES;
            default: return 13 * (d_long  + 1) + 3 + GUARD_CYCLES;
        endcase
    endfunction

    task automatic model_edge();
        logic [3:0] req;
        logic [3:0] gmask;
        logic [1:0] g;
        if (!rst_n) begin
            m_pend = 4'b0000; m_left = 0; m_elapsed = 0; m_type = 2'b00; m_coal = 1'b0;
            return;
        end
        req   = {req_victory, req_error, req_drop, req_start};
        gmask = 4'b0000;
        m_coal = sound_en && ((req & m_pend) != 4'b0000);
        if (m_left > 0) begin
            m_left--;
            m_elapsed++;
        end else if (sound_en && m_pend != 4'b0000) begin
            if (m_pend[3])      g = 2'd3;
            else if (m_pend[2]) g = 2'd2;
            else if (m_pend[0]) g = 2'd0;
            else                g = 2'd1;
            m_type    = g;
            m_left    = STROBE_CYCLES + melody_wait(g);
            m_elapsed = 0;
            gmask[g]  = 1'b1;
        end
        m_pend = sound_en ? ((m_pend | req) & ~gmask) : 4'b0000;
    endtask

    function automatic logic [4:0] model_out();
        logic s;
        logic b;
        b = (m_left > 0);
        s = !(b && (m_elapsed < STROBE_CYCLES));
        return {s, m_type, b, m_coal};
    endfunction

    // Observation of busy windows and strobes, sampled on the falling edge.
    int   win_len[$];
    int   win_type[$];
    int   win_low[$];
    int   gap_q[$];
    int   cur_len = 0, cur_low = 0, cur_gap = 0, type_changed = 0;
    int   coal_cnt = 0, start_low_total = 0, start_fall_cnt = 0;
    logic [1:0] cur_type = 2'b00;
    logic prev_busy = 1'b0;
    logic prev_start = 1'b1;

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (prev_busy !== 1'b1) begin
                gap_q.push_back(cur_gap);
                cur_len = 0; cur_low = 0; cur_type = sound_type;
            end
            cur_len++;
            if (sound_type !== cur_type) type_changed++;
            if (sound_start === 1'b0) cur_low++;
        end else begin
            if (prev_busy === 1'b1) begin
                win_len.push_back(cur_len);
                win_type.push_back(int'(cur_type));
                win_low.push_back(cur_low);
                cur_gap = 0;
            end
            cur_gap++;
        end
        if (coalesced === 1'b1) coal_cnt++;
        if (sound_start === 1'b0) start_low_total++;
        if (prev_start === 1'b1 && sound_start === 1'b0) start_fall_cnt++;
        prev_busy  = busy;
        prev_start = sound_start;
    end

    task automatic clear_obs();
        win_len.delete(); win_type.delete(); win_low.delete(); gap_q.delete();
        type_changed = 0; coal_cnt = 0; start_low_total = 0; start_fall_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input logic [3:0] mask);
        {req_victory, req_error, req_drop, req_start} = mask;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sound_en = 1'b1; set_req(4'b0000);
        repeat (3) tick();
        tests_run += 4;
        if (sound_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_start: got %b expected 1", sound_start); end
        if (sound_type !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_type: got %b expected 00", sound_type); end
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (coalesced !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_coal: got %b expected 0", coalesced); end
        rst_n = 1'b1;
        set_req(4'b1000);
        for (int i = 0; i < 60; i++) begin
            tick();
            set_req(4'b0000);
            if (i == 30) set_req(4'b0100);
            tests_run++;
            if ({sound_start, sound_type, busy, coalesced} !== model_out()) begin
                tests_failed++;
                $display("[TB] FAIL reset_pre_cycle%0d: got %b expected %b", i, {sound_start, sound_type, busy, coalesced}, model_out());
            end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if ({sound_start, sound_type, busy, coalesced} !== 5'b10000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_play: got %b expected 10000", {sound_start, sound_type, busy, coalesced});
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (busy !== 1'b0 || sound_start !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset_pending_cleared%0d: got busy=%b start=%b expected busy=0 start=1", i, busy, sound_start);
            end
        end
    endtask

    task automatic test_single_drop();
        clear_obs();
        set_req(4'b0010);
        for (int i = 0; i < 130; i++) begin
            tick();
            set_req(4'b0000);
            tests_run++;
            if ({sound_start, sound_type, busy, coalesced} !== model_out()) begin
                tests_failed++;
                $display("[TB] FAIL drop_cycle%0d: got %b expected %b", i, {sound_start, sound_type, busy, coalesced}, model_out());
            end
        end
        tests_run++;
        if (win_len.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL drop_windows: got %0d expected 1", win_len.size());
        end else begin
            tests_run += 3;
            if (win_len[0] != 103) begin tests_failed++; $display("[TB] FAIL drop_busy_len: got %0d expected 103", win_len[0]); end
            if (win_low[0] != 2) begin tests_failed++; $display("[TB] FAIL drop_strobe_len: got %0d expected 2", win_low[0]); end
            if (win_type[0] != 1) begin tests_failed++; $display("[TB] FAIL drop_type: got %0d expected 1", win_type[0]); end
        end
    endtask

    task automatic test_priority();
        int exp_len[3];
        int exp_type[3];
        exp_len  = '{1334, 425, 103};
        exp_type = '{3, 0, 1};
        clear_obs();
        set_req(4'b1011);
        for (int i = 0; i < 1900; i++) begin
            tick();
            set_req(4'b0000);
            tests_run++;
            if ({sound_start, sound_type, busy, coalesced} !== model_out()) begin
                tests_failed++;
                $display("[TB] FAIL prio_cycle%0d: got %b expected %b", i, {sound_start, sound_type, busy, coalesced}, model_out());
            end
        end
        tests_run += 2;
        if (type_changed != 0) begin tests_failed++; $display("[TB] FAIL prio_type_stable: got %0d changes expected 0", type_changed); end
        if (win_len.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL prio_windows: got %0d expected 3", win_len.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests_run += 2;
                if (win_type[k] != exp_type[k]) begin tests_failed++; $display("[TB] FAIL prio_type%0d: got %0d expected %0d", k, win_type[k], exp_type[k]); end
                if (win_len[k] != exp_len[k]) begin tests_failed++; $display("[TB] FAIL prio_len%0d: got %0d expected %0d", k, win_len[k], exp_len[k]); end
            end
        end
    endtask

    task automatic test_coalesce();
        clear_obs();
        set_req(4'b1000);
        for (int i = 0; i < 1600; i++) begin
            tick();
            set_req(4'b0000);
            if (i == 100 || i == 300) set_req(4'b0100);
            tests_run++;
            if ({sound_start, sound_type, busy, coalesced} !== model_out()) begin
                tests_failed++;
                $display("[TB] FAIL coal_cycle%0d: got %b expected %b", i, {sound_start, sound_type, busy, coalesced}, model_out());
            end
        end
        tests_run += 2;
        if (coal_cnt != 1) begin tests_failed++; $display("[TB] FAIL coal_pulses: got %0d expected 1", coal_cnt); end
        if (win_type.size() != 2) begin
            tests_failed++;
            $display("[TB] FAIL coal_windows: got %0d expected 2", win_type.size());
        end else begin
            tests_run++;
            if (win_type[0] != 3 || win_type[1] != 2) begin
                tests_failed++;
                $display("[TB] FAIL coal_order: got %0d,%0d expected 3,2", win_type[0], win_type[1]);
            end
        end
    endtask

    task automatic test_mute();
        clear_obs();
        sound_en = 1'b0;
        set_req(4'b0001);
        for (int i = 0; i < 20; i++) begin
            tick();
            set_req(4'b0000);
            tests_run++;
            if (busy !== 1'b0 || sound_start !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL mute_idle%0d: got busy=%b start=%b expected busy=0 start=1", i, busy, sound_start);
            end
        end
        sound_en = 1'b1;
        set_req(4'b1000);
        for (int i = 0; i < 1400; i++) begin
            tick();
            set_req(4'b0000);
            if (i == 200) set_req(4'b0100);
            if (i == 210) sound_en = 1'b0;
            if (i == 1380) sound_en = 1'b1;
            tests_run++;
            if ({sound_start, sound_type, busy, coalesced} !== model_out()) begin
                tests_failed++;
                $display("[TB] FAIL mute_cycle%0d: got %b expected %b", i, {sound_start, sound_type, busy, coalesced}, model_out());
            end
        end
        tests_run++;
        if (win_len.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL mute_windows: got %0d expected 1", win_len.size());
        end else begin
            tests_run++;
            if (win_len[0] != 1334 || win_type[0] != 3) begin
                tests_failed++;
                $display("[TB] FAIL mute_play_completes: got len=%0d type=%0d expected len=1334 type=3", win_len[0], win_type[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        set_req(4'b0010);
        for (int i = 0; i < 220; i++) begin
            tick();
            set_req(4'b0000);
            if (i == 20) set_req(4'b0010);
            tests_run++;
            if ({sound_start, sound_type, busy, coalesced} !== model_out()) begin
                tests_failed++;
                $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", i, {sound_start, sound_type, busy, coalesced}, model_out());
            end
        end
        tests_run += 2;
        if (start_fall_cnt != 2) begin tests_failed++; $display("[TB] FAIL b2b_strobes: got %0d expected 2", start_fall_cnt); end
        if (win_len.size() != 2 || gap_q.size() != 2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_windows: got %0d windows %0d gaps expected 2 and 2", win_len.size(), gap_q.size());
        end else begin
            tests_run += 2;
            if (gap_q[1] != 1) begin tests_failed++; $display("[TB] FAIL b2b_gap: got %0d expected 1", gap_q[1]); end
            if (win_len[1] != 103 || win_type[1] != 1) begin
                tests_failed++;
                $display("[TB] FAIL b2b_second: got len=%0d type=%0d expected len=103 type=1", win_len[1], win_type[1]);
            end
        end
    endtask

    task automatic test_random();
        sound_en = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            tick();
            set_req(4'b0000);
            if ($urandom_range(0, 29) == 0) set_req(4'($urandom_range(1, 15)));
            sound_en = ($urandom_range(0, 99) < 97);
            tests_run++;
            if ({sound_start, sound_type, busy, coalesced} !== model_out()) begin
                tests_failed++;
                $display("[TB] FAIL random_cycle%0d: got %b expected %b", i, {sound_start, sound_type, busy, coalesced}, model_out());
            end
        end
        sound_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        sound_en = 1'b1;
        set_req(4'b0000);
        test_reset();
        test_single_drop();
        test_priority();
        test_coalesce();
        test_mute();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
- Sits between the game FSM and the game_sounds player.
- Accepts single-cycle sound requests: start, drop, error and victory.
- Queues them as one pending bit per type and grants them in fixed priority.
- Drives the player's falling-edge start strobe and holds sound_type stable for the whole melody. The player exposes no done signal, so a local timer models its busy time.

Parameters:
- CLK_FREQ, 25_000_000, system clock in Hz. Must match the player.
- GUARD_CYCLES, 16, idle cycles added after each melody before the next grant.
- STROBE_CYCLES, 2, number of cycles sound_start is held low per grant. Legal range 1..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sound_en  in  1  1 = sounds enabled; 0 = muted
- req_start  in  1  one-cycle pulse requesting the start jingle
- req_drop  in  1  one-cycle pulse requesting the drop sound
- req_error  in  1  one-cycle pulse requesting the error sound
- req_victory  in  1  one-cycle pulse requesting the victory melody
- sound_start  out  1  to player start; idle high, low pulse triggers playback
- sound_type  out  2  to player sound_type; 00 start, 01 drop, 10 error, 11 victory
- busy  out  1  high while strobing or while the player is modelled as playing
- coalesced  out  1  one-cycle pulse when a request merges into an already-pending one

Behaviour:
- Reset is synchronous on rst_n=0. All outputs are registered.
  - State = IDLE; pending = 0000.
  - sound_start = 1, sound_type = 00, busy = 0, coalesced = 0.
  - Counters = 0.
- Pending bits:
  - A request pulse sets its type's bit.
  - If the bit is already set, the bit stays set and coalesced pulses the next cycle.
  - Several request inputs may be high in one cycle; each is handled independently. coalesced pulses once if any of them merged.
- Mute: while sound_en=0, requests are ignored and pending is cleared. An in-progress STROBE/PLAY still completes, because the player cannot be aborted.
- Priority: victory > error > start > drop.
- Durations:
  - D_LONG = CLK_FREQ/10 (start, error, victory). D_SHORT = CLK_FREQ/25 (drop).
  - Notes: start 4, drop 2, error 2, victory 13.
  - WAIT = notes*(D+1) + 3 + GUARD_CYCLES. The +3 covers the player's start synchroniser.
  - The wait counter width is $clog2 of the victory WAIT, plus 1.
- FSM:
  - IDLE: if sound_en and pending≠0, grant the highest-priority type (edge at cycle t). At that edge:
    - sound_type <= granted type and sound_start <= 0.
    - The granted bit is cleared. A same-type request in the same cycle is absorbed and also pulses coalesced.
    - busy <= 1; strobe counter <= STROBE_CYCLES-1; go to STROBE.
  - STROBE: sound_start stays 0 until the strobe counter reaches 0. Then sound_start <= 1, the wait counter loads WAIT-1, and the FSM goes to PLAY.
  - PLAY: the wait counter decrements each cycle. At 0: busy <= 0 and go to IDLE. sound_type holds its value in IDLE.
  - A new grant can occur on the first IDLE cycle.
- Latency:
  - Request in IDLE with nothing pending → grant edge on the next edge. sound_start is low during cycles t+1..t+STROBE_CYCLES.
  - busy is high for exactly STROBE_CYCLES + WAIT cycles.
- sound_type never changes while busy=1.
- Requests arriving during STROBE/PLAY wait in pending. Nothing is dropped except by coalescing or mute.

Test Plan:
- Use CLK_FREQ=1000 (D_LONG=100, D_SHORT=40), GUARD_CYCLES=16, STROBE_CYCLES=2.
- Reset → sound_start=1, sound_type=00, busy=0, pending=0. Assert rst_n=0 mid-PLAY → the same values appear on the next edge.
- Single req_drop in IDLE:
  - sound_type=01.
  - sound_start low for exactly 2 cycles.
  - busy high for 2+82+3+16=103 cycles, then returns to 0.
  - With the real player attached, the buzzer is active during the busy window.
- req_drop, req_start, req_victory in the same cycle:
  - Grants in order victory (busy 2+1313+19=1334 cycles), then start (2+404+19), then drop.
  - sound_type is constant within each busy window.
- Two req_error pulses during a victory PLAY:
  - coalesced pulses once.
  - error plays exactly once after victory.
- sound_en=0 with req_start pulsed → no strobe, busy stays 0. sound_en=0 during a PLAY with error pending → PLAY completes, error is discarded, and the scheduler returns to IDLE.
- Back-to-back: req_drop is held pending across the drop busy end → a new grant occurs on the first IDLE cycle, sound_start returns high between the two strobes, and the player retriggers.
